fetch_unit: RTL and testbench

Instruction-fetch front end placed directly upstream of the decode/execute core of my_cpu. Owns the fetch PC and issues word reads to the synchronous instruction memory (u_im). Buffers returned instructions in a small queue and hands them to decode over a valid/ready handshake. Accepts branch/jump redirects from execute and squashes wrong-path fetches.

---
 rtl/cpu_defs.sv | 10 +
 rtl/fetch_unit_if.sv | 22 ++
 rtl/fetch_fifo.sv | 39 +++
 rtl/fetch_unit.sv | 56 +++++
 tb/tb_fetch_unit.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/cpu_defs.sv
// cpu_defs: shared constants and the fetch queue entry type for the my_cpu front end.
package cpu_defs;
  localparam int INST_W = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP = 32'h0000_0000;
  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory port, redirect input and decode handshake of the fetch unit.
interface fetch_unit_if #(parameter int ADDR_W = 10);
  import cpu_defs::*;
  logic              im_en;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_rdata;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [31:0]       inst_pc;
  logic [31:0]       inst_pc4;
  modport master (
    output im_en, im_addr, inst_valid, inst, inst_pc, inst_pc4,
    input  im_rdata, redirect_valid, redirect_pc, inst_ready
  );
  modport slave (
    input  im_en, im_addr, inst_valid, inst, inst_pc, inst_pc4,
    output im_rdata, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: in-order {pc,inst} queue with flush; head is read straight from the storage registers.
module fetch_fifo import cpu_defs::*; #(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  fetch_entry_t                 data_i,
  output fetch_entry_t                 data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    rd_d  = flush_i ? '0 : pop_i ? (rd_q == PW'(DEPTH-1) ? '0 : rd_q + 1'b1) : rd_q;
    wr_d  = flush_i ? '0 : push_i ? (wr_q == PW'(DEPTH-1) ? '0 : wr_q + 1'b1) : wr_q;
    cnt_d = flush_i ? '0 : cnt_q + CW'(push_i) - CW'(pop_i);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '{pc: '0, inst: NOP};
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i && !flush_i) mem_q[wr_q] <= data_i;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the fetch PC, issues credit-limited instruction-memory reads and queues
// returned words for decode; redirects flush the queue and squash the in-flight read.
module fetch_unit import cpu_defs::*; #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH+1);
  logic [31:0]   fpc_q, fpc_d, pend_pc_q, pend_pc_d;
  logic          pending_q, pending_d;
  logic          pop, push;
  logic [CW-1:0] count;
  logic [CW:0]   used;
  fetch_entry_t  head, wr_entry;
  assign pop  = bus.inst_valid & bus.inst_ready;
  assign push = pending_q & !bus.redirect_valid;
  // Slots already promised: queued words plus the read still in flight, minus what leaves now.
  assign used        = {1'b0, count} + (CW+1)'(pending_q) - (CW+1)'(pop);
  assign bus.im_en   = !rst & !bus.redirect_valid & (used < (CW+1)'(DEPTH));
  assign bus.im_addr = fpc_q[ADDR_W+1:2];
  assign wr_entry    = '{pc: pend_pc_q, inst: bus.im_rdata};
  always_comb begin
    fpc_d     = bus.redirect_valid ? (bus.redirect_pc & ~32'd3) : bus.im_en ? fpc_q + 32'd4 : fpc_q;
    pending_d = bus.im_en;
    pend_pc_d = bus.im_en ? fpc_q : pend_pc_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc_q     <= RESET_PC;
      pending_q <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      fpc_q     <= fpc_d;
      pending_q <= pending_d;
      pend_pc_q <= pend_pc_d;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.redirect_valid),
    .data_i  (wr_entry),
    .data_o  (head),
    .count_o (count)
  );
  assign bus.inst_valid = count != '0;
  assign bus.inst       = head.inst;
  assign bus.inst_pc    = head.pc;
  assign bus.inst_pc4   = rst ? '0 : head.pc + 32'd4;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table, directed corner sequences and random traffic checked against
// a delivered-stream model (next expected pc, memory contents, head stability, latency bound).
module tb_fetch_unit;
  import cpu_defs::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fetch_unit_if #(.ADDR_W(10)) bus();
  fetch_unit #(.ADDR_W(10), .RESET_PC(32'h0), .DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [31:0] mem [1024];
  always @(posedge clk) bus.im_rdata <= bus.im_en ? mem[bus.im_addr] : 32'hDEAD_BEEF;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_pc;
  bit          hold_q;
  logic [31:0] hold_pc;
  int          idle;
  typedef struct {
    bit          rb;
    bit          ready;
    bit          rv;
    logic [31:0] rpc;
    bit          en;
    logic [9:0]  addr;
    bit          vld;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;
  vec_t tbl[$];
  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return mem[pc[11:2]];
  endfunction
  function automatic vec_t mk(input bit rb, input bit rdy, input bit rv, input logic [31:0] rpc,
                              input bit en, input int addr, input bit vld, input logic [31:0] pc);
    vec_t v;
    v.rb = rb; v.ready = rdy; v.rv = rv; v.rpc = rpc;
    v.en = en; v.addr = 10'(addr); v.vld = vld; v.pc = pc; v.inst = mem_word(pc);
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    exp_pc = 32'h0;
    hold_q = 1'b0;
    idle   = 0;
  endtask
  task automatic model_check(input bit ready, input bit rv, input logic [31:0] rpc);
    if (rv) chk("no_req_on_redirect", 32'(bus.im_en), 32'd0);
    if (hold_q) begin
      chk("hold_valid", 32'(bus.inst_valid), 32'd1);
      chk("hold_pc", bus.inst_pc, hold_pc);
    end
    if (bus.inst_valid) begin
      chk("seq_pc", bus.inst_pc, exp_pc);
      chk("seq_inst", bus.inst, mem_word(exp_pc));
      chk("seq_pc4", bus.inst_pc4, exp_pc + 32'd4);
      idle = 0;
    end else idle++;
    if (idle > 3) begin
      n_cmp++;
      n_bad++;
      $display("FAIL latency: no instruction for %0d cycles at %0t", idle, $time);
      idle = 0;
    end
    hold_q  = bus.inst_valid & !ready & !rv;
    hold_pc = bus.inst_pc;
    if (bus.inst_valid && ready) exp_pc = exp_pc + 32'd4;
    if (rv) begin
      exp_pc = rpc & ~32'd3;
      idle   = 0;
    end
  endtask
  task automatic step(input bit ready, input bit rv, input logic [31:0] rpc);
    @(negedge clk);
    bus.inst_ready     = ready;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    #1;
    model_check(ready, rv, rpc);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_en", 32'(bus.im_en), 32'd0);
    chk("rst_inst", bus.inst, 32'd0);
    chk("rst_pc", bus.inst_pc, 32'd0);
    chk("rst_pc4", bus.inst_pc4, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask
  initial begin
    bus.inst_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i * 32'h0001_0011;
    mem[0] = 32'h2401_0002;
    mem[1] = 32'h3C00_0003;
    // streaming from reset, then redirect to an unaligned target
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 2, 1, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 3, 1, 32'h4));
    tbl.push_back(mk(0, 1, 1, 32'h13, 0, 0, 1, 32'h8));
    tbl.push_back(mk(0, 1, 0, 0, 1, 4, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 5, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 6, 1, 32'h10));
    tbl.push_back(mk(0, 1, 0, 0, 1, 7, 1, 32'h14));
    // decode stalled five cycles: queue fills to two, requests stop
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 2, 1, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 3, 1, 32'h4));
    tbl.push_back(mk(0, 1, 0, 0, 1, 4, 1, 32'h8));
    // redirect to 0x2C while 0x1C is in flight, then to the top of the address space
    for (int k = 0; k < 8; k++) tbl.push_back(mk(k == 0, 1, 0, 0, 1, k, k >= 2, k >= 2 ? 32'(4 * (k - 2)) : 32'h0));
    tbl.push_back(mk(0, 1, 1, 32'h2C, 0, 0, 1, 32'h18));
    tbl.push_back(mk(0, 1, 0, 0, 1, 11, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 12, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 13, 1, 32'h2C));
    tbl.push_back(mk(0, 1, 1, 32'hFFFF_FFF8, 0, 0, 1, 32'h30));
    tbl.push_back(mk(0, 1, 0, 0, 1, 'h3FE, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 'h3FF, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 32'hFFFF_FFF8));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 1, 32'hFFFF_FFFC));
    tbl.push_back(mk(0, 1, 0, 0, 1, 2, 1, 32'h0));
    foreach (tbl[i]) begin
      if (tbl[i].rb) do_reset();
      step(tbl[i].ready, tbl[i].rv, tbl[i].rpc);
      chk($sformatf("row%0d_im_en", i), 32'(bus.im_en), 32'(tbl[i].en));
      if (tbl[i].en) chk($sformatf("row%0d_im_addr", i), 32'(bus.im_addr), 32'(tbl[i].addr));
      chk($sformatf("row%0d_valid", i), 32'(bus.inst_valid), 32'(tbl[i].vld));
      if (tbl[i].vld) begin
        chk($sformatf("row%0d_pc", i), bus.inst_pc, tbl[i].pc);
        chk($sformatf("row%0d_inst", i), bus.inst, tbl[i].inst);
      end
    end
    // async reset in the middle of a fetch with a word in flight and one queued
    do_reset();
    for (int k = 0; k < 3; k++) step(0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(bus.inst_valid), 32'd0);
    chk("async_rst_en", 32'(bus.im_en), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    step(1, 0, 0);
    chk("restart_en", 32'(bus.im_en), 32'd1);
    chk("restart_addr", 32'(bus.im_addr), 32'd0);
    for (int k = 0; k < 6; k++) step(1, 0, 0);
    // j 0 loop: redirect to 0 together with a pop every fourth cycle
    do_reset();
    for (int n = 0; n < 5; n++) begin
      for (int k = 0; k < 3; k++) step(1, 0, 0);
      step(1, 1, 32'h0);
    end
    for (int k = 0; k < 4; k++) step(1, 0, 0);
    // random traffic including back-to-back redirects and stalls
    do_reset();
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
